// File: rtl/hyper_addr_pkg.sv
// Shared types for the hyperbus address splitter: per-CS range records,
// FSM state encoding and default widths.
package hyper_addr_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 32;
  localparam int unsigned LEN_WIDTH_DEFAULT  = 16;

  typedef struct packed {
    logic [31:0] start;
    logic [31:0] last;
  } addr_range_t;

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_t;

  // Each CS occupies 64 bits of the map vector: start in the low word, last in the high word.
  function automatic addr_range_t unpack_range(input logic [63:0] slice);
    addr_range_t r;
    r.start = slice[31:0];
    r.last  = slice[63:32];
    return r;
  endfunction

endpackage

// File: rtl/hyper_cs_match.sv
// Combinational chip-select decoder: lowest-index range containing the
// address wins, so overlapping ranges resolve toward CS0.
module hyper_cs_match
  import hyper_addr_pkg::*;
#(
  parameter int NR_CS      = 2,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  addr_range_t             ranges [NR_CS],
  input  logic [ADDR_WIDTH-1:0]   addr,
  output logic                    hit,
  output logic [NR_CS-1:0]        cs,
  output logic [ADDR_WIDTH-1:0]   base_start,
  output logic [ADDR_WIDTH-1:0]   base_last
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    hit        = 1'b0;
    cs         = '0;
    base_start = '0;
    base_last  = '0;
    // Walk from the top index down so the lowest matching index is written last.
    for (int i = NR_CS - 1; i >= 0; i--) begin
      if (addr >= ADDR_WIDTH'(ranges[i].start) && addr <= ADDR_WIDTH'(ranges[i].last)) begin
        hit        = 1'b1;
        cs         = NR_CS'(1) << i;
        base_start = ADDR_WIDTH'(ranges[i].start);
        base_last  = ADDR_WIDTH'(ranges[i].last);
      end
    end
  end

endmodule

// File: rtl/hyper_addr_splitter.sv
// Splits linear burst requests into per-chip-select fragments with local
// addresses; unmapped or zero-length requests yield a single error fragment.
module hyper_addr_splitter
  import hyper_addr_pkg::*;
#(
  parameter int NR_CS      = 2,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [64*NR_CS-1:0]   addr_mapping_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]  req_len_i,
  input  logic                  req_write_i,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic [NR_CS-1:0]      tx_cs_o,
  output logic [ADDR_WIDTH-1:0] tx_addr_o,
  output logic [LEN_WIDTH-1:0]  tx_len_o,
  output logic                  tx_write_o,
  output logic                  tx_last_o,
  output logic                  tx_err_o
);

  localparam int CW = (ADDR_WIDTH + 1 > LEN_WIDTH) ? ADDR_WIDTH + 1 : LEN_WIDTH;

  state_t                state_q;
  addr_range_t           map_in   [NR_CS];
  addr_range_t           map_q    [NR_CS];
  addr_range_t           calc_map [NR_CS];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  write_q;

  logic [ADDR_WIDTH-1:0] calc_addr;
  logic [LEN_WIDTH-1:0]  calc_rem;
  logic                  m_hit;
  logic [NR_CS-1:0]      m_cs;
  logic [ADDR_WIDTH-1:0] m_start;
  logic [ADDR_WIDTH-1:0] m_last;
  logic [CW-1:0]         span;
  logic [LEN_WIDTH-1:0]  frag_len;
  logic                  frag_err;

  assign req_ready_o = (state_q == ST_IDLE) && !rst_i;

  always_comb begin
    for (int i = 0; i < NR_CS; i++) begin
      map_in[i] = unpack_range(addr_mapping_i[64*i +: 64]);
    end
  end

  // In IDLE the fragment is computed from the incoming request; in EMIT from the
  // position just past the fragment currently on the output.
  always_comb begin
    if (state_q == ST_IDLE) begin
      calc_addr = req_addr_i;
      calc_rem  = req_len_i;
      calc_map  = map_in;
    end else begin
      calc_addr = addr_q + ADDR_WIDTH'(tx_len_o);
      calc_rem  = rem_q - tx_len_o;
      calc_map  = map_q;
    end
  end

  hyper_cs_match #(
    .NR_CS      (NR_CS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_match (
    .ranges     (calc_map),
    .addr       (calc_addr),
    .hit        (m_hit),
    .cs         (m_cs),
    .base_start (m_start),
    .base_last  (m_last)
  );

  // Span is one bit wider than the address so a range ending at all-ones does not wrap.
  assign span     = CW'({1'b0, m_last}) - CW'({1'b0, calc_addr}) + CW'(1);
  assign frag_len = (CW'(calc_rem) <= span) ? calc_rem : LEN_WIDTH'(span);
  assign frag_err = !m_hit || (calc_rem == '0);

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q    <= ST_IDLE;
      tx_valid_o <= 1'b0;
      tx_cs_o    <= '0;
      tx_addr_o  <= '0;
      tx_len_o   <= '0;
      tx_write_o <= 1'b0;
      tx_last_o  <= 1'b0;
      tx_err_o   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            state_q    <= ST_EMIT;
            tx_valid_o <= 1'b1;
            tx_write_o <= req_write_i;
            tx_err_o   <= frag_err;
            tx_cs_o    <= frag_err ? '0 : m_cs;
            tx_addr_o  <= frag_err ? calc_addr : calc_addr - m_start;
            tx_len_o   <= frag_err ? calc_rem : frag_len;
            tx_last_o  <= frag_err || (frag_len == calc_rem);
          end
        end
        ST_EMIT: begin
          if (tx_ready_i) begin
            if (tx_last_o) begin
              state_q    <= ST_IDLE;
              tx_valid_o <= 1'b0;
            end else begin
              tx_err_o  <= frag_err;
              tx_cs_o   <= frag_err ? '0 : m_cs;
              tx_addr_o <= frag_err ? calc_addr : calc_addr - m_start;
              tx_len_o  <= frag_err ? calc_rem : frag_len;
              tx_last_o <= frag_err || (frag_len == calc_rem);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: request context is only consumed while EMIT is active, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_IDLE && req_valid_i && !rst_i) begin
      addr_q  <= req_addr_i;
      rem_q   <= req_len_i;
      write_q <= req_write_i;
      map_q   <= map_in;
    end else if (state_q == ST_EMIT && tx_ready_i && !tx_last_o) begin
      addr_q <= calc_addr;
      rem_q  <= calc_rem;
    end
  end

  // write_q mirrors the latched request direction; the output register already carries it.
  logic unused_write;
  assign unused_write = write_q;

endmodule

// File: doc/hyper_addr_splitter.md
# hyper_addr_splitter

Sits directly downstream of the hyperbus configuration register block and upstream of the hyperbus controller FSM. Takes linear-address burst requests, decodes them against the per-chip-select address map, and emits one or more per-CS fragments, each with a local address. A burst that crosses a CS boundary is split. An unmapped region produces an error fragment.

## Interface
- `NR_CS`, 2, number of chip selects.
- `ADDR_WIDTH`, 32, address width, in the same units as the address map.
- `LEN_WIDTH`, 16, burst-length width, counted in address units.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `addr_mapping_i` in 64*NR_CS: address map. CS i start is at [64i+31:64i] and CS i last (inclusive) is at [64i+63:64i+32].
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request ready.
- `req_addr_i` in ADDR_WIDTH: linear start address.
- `req_len_i` in LEN_WIDTH: unit count. 0 is illegal.
- `req_write_i` in 1: 1 = write.
- `tx_valid_o` out 1: fragment valid.
- `tx_ready_i` in 1: fragment accepted.
- `tx_cs_o` out NR_CS: one-hot CS select. All zero on an error fragment.
- `tx_addr_o` out ADDR_WIDTH: local offset (addr − start). Absolute address on an error fragment.
- `tx_len_o` out LEN_WIDTH: fragment unit count.
- `tx_write_o` out 1: copy of `req_write_i`.
- `tx_last_o` out 1: final fragment of the request.
- `tx_err_o` out 1: unmapped address or zero length.

## Operation
- **FSM states:** IDLE and EMIT.
- **IDLE:**
  - `req_ready_o`=1 (0 while `rst_i`=1).
  - On `req_valid_i & req_ready_o`, latch addr, remaining=len, write and `addr_mapping_i`, compute the first fragment, then go to EMIT.
  - The map is latched per request; changes to `addr_mapping_i` mid-request have no effect until the next accept.
- **Fragment computation:**
  - Match = lowest CS index i with start_i ≤ addr ≤ last_i, all comparisons unsigned. Overlapping ranges resolve to the lower index.
  - On a match:
    - span = last_i − addr + 1, computed in ADDR_WIDTH+1 bits (no wrap at last = all-ones).
    - frag_len = min(remaining, span), with remaining zero-extended.
    - `tx_cs_o` = 1<<i, `tx_addr_o` = addr − start_i, `tx_err_o`=0.
    - `tx_last_o` = (frag_len == remaining).
  - On no match, or remaining == 0: `tx_err_o`=1, `tx_cs_o`=0, `tx_addr_o`=addr, `tx_len_o`=remaining, `tx_last_o`=1.
- **EMIT:**
  - `tx_valid_o`=1. All `tx_*` outputs are held stable until `tx_ready_i`.
  - On a handshake with `tx_last_o`=0: addr += frag_len (modulo 2^ADDR_WIDTH), remaining −= frag_len, compute the next fragment, stay in EMIT.
  - On a handshake with `tx_last_o`=1: go to IDLE.
- The error fragment always terminates the request. The remaining units are not retried.

## Timing
- **Reset:** while `rst_i`=1 at a clock edge, state → IDLE and every output → 0. `req_ready_o` is also forced 0 combinationally during reset.
- **Reset mid-operation:** the in-flight fragment and request are discarded without a handshake.
- **Latency:** accept at cycle T → first fragment valid at T+1.
- **Fragments:** a handshake at F with more fragments pending → next fragment valid at F+1, no bubble.
- **Between requests:** final handshake at F → `req_ready_o`=1 at F+1 → next first fragment at F+2 at the earliest. There is one idle cycle between requests.
- **Back-pressure:** `req_ready_o`=0 throughout EMIT. There is no combinational path from `tx_ready_i` to `req_ready_o`.
- **Registers:** all `tx_*` outputs are registered. `req_ready_o` is decoded from state and `rst_i`.

## Structure
- **Package `hyper_addr_pkg`:**
  - `addr_range_t` {start, last} and the unpacking function from the 64*NR_CS vector.
  - FSM state enum.
  - Default `ADDR_WIDTH`/`LEN_WIDTH` constants.
- **Sub-module `hyper_cs_match`:** purely combinational. Inputs are the range array and the address; outputs are hit, one-hot CS, base start and last. Implemented as a priority encoder, lowest index wins.
- **Top level:** holds the FSM, the latched map, the addr/remaining registers and the output register.

## Test plan
- **Single fragment.** Default map {0..3FFFFF, 400000..7FFFFF}, addr 0x100, len 16 → one fragment: cs=01, addr 0x100, len 16, last=1, err=0. Valid at T+1.
- **Boundary split.** addr 0x3FFFF8, len 16, `tx_ready_i`=1 → frag1 cs=01, addr 0x3FFFF8, len 8, last=0; then frag2 in the next cycle: cs=10, addr 0, len 8, last=1. `req_ready_o`=1 one cycle later.
- **Unmapped.** addr 0x800000, len 4 → single fragment: err=1, cs=00, addr 0x800000, len 4, last=1. Also len 0 at addr 0 → err=1, len 0, last=1.
- **Partial map.** CS1 range set to 800000..BFFFFF, addr 0x3FFFF8, len 16 → cs=01 len 8 last=0, then err=1 addr 0x400000 len 8 last=1.
- **Back-pressure / map stability.** Hold `tx_ready_i`=0 for 5 cycles and change `addr_mapping_i` mid-burst → outputs are stable, `req_ready_o`=0, and the split follows the latched map.
- **Reset mid-request.** Assert `rst_i` for 1 cycle during frag1 of the boundary split → all outputs 0 on the next cycle and `req_ready_o`=1 after release. No frag2 is ever emitted.
